// File: rtl/serial_shift_right_pkg.sv
// serial_shift_right_pkg: shared definitions for the multicycle ALU units
//   ALU_WIDTH : default datapath width
//   state_t   : IDLE / SHIFT / DONE sequencing states
package serial_shift_right_pkg;
    localparam int ALU_WIDTH = 8;
    localparam int ALU_SHW   = $clog2(ALU_WIDTH);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shr_step.sv
// shr_step: one-position right shift with an explicit fill bit
//   x_i    : value to shift
//   fill_i : bit inserted at the MSB
//   y_o    : {fill_i, x_i[WIDTH-1:1]}
module shr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = {fill_i, x_i[WIDTH-1:1]};
endmodule

// File: rtl/serial_shift_right.sv
// serial_shift_right: multicycle logical/arithmetic right shifter, one bit per clock
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request a shift, accepted only in IDLE
//   desplazar   : operand, captured on the accepted start
//   cantidad    : shift amount, captured on the accepted start
//   aritmetico  : 1 = sign fill, 0 = zero fill, captured on the accepted start
//   busy        : high while a shift is in progress (SHIFT or DONE)
//   done        : one-cycle pulse when desplazados holds the result
//   desplazados : result register, held until the next accepted start
module serial_shift_right
    import serial_shift_right_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] desplazar,
    input  logic [SHW-1:0]   cantidad,
    input  logic             aritmetico,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] desplazados
);
    state_t           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] res_q, res_d, step;

    shr_step #(.WIDTH(WIDTH)) u_step (
        .x_i    (res_q),
        .fill_i (mode_q & res_q[WIDTH-1]),
        .y_o    (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SHIFT;
                count_d = cantidad;
                mode_d  = aritmetico;
                res_d   = desplazar;
            end
            SHIFT: if (count_q != '0) begin
                count_d = count_q - 1'b1;
                res_d   = step;
            end else begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally.
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign desplazados = res_q;
endmodule

// File: tb/tb_serial_shift_right.sv
// tb_serial_shift_right: randomized self-checking bench for serial_shift_right
module tb_serial_shift_right;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       aritmetico = 1'b0;
    logic [7:0] desplazar = 8'h00;
    logic [2:0] cantidad = 3'd0;
    logic       busy, done;
    logic [7:0] desplazados;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] last_res;

    always #5 clk = ~clk;

    serial_shift_right #(.WIDTH(8), .SHW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .desplazar   (desplazar),
        .cantidad    (cantidad),
        .aritmetico  (aritmetico),
        .busy        (busy),
        .done        (done),
        .desplazados (desplazados)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic shift of a negative value is the complement of a logical shift of its complement.
    function automatic logic [7:0] ref_shr(input logic [7:0] d, input int k, input logic a);
        return (a && d[7]) ? ~((~d) >> k) : d >> k;
    endfunction

    task automatic run_shift(input logic [7:0] d, input int k, input logic a, input bit rp);
        int n;
        logic [7:0] exp;
        exp = ref_shr(d, k, a);
        @(negedge clk);
        start = 1'b1;
        desplazar = d;
        cantidad = 3'(k);
        aritmetico = a;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 1);
        start = rp;
        desplazar = rp ? 8'h0F : 8'($urandom);
        cantidad = rp ? 3'd1 : 3'($urandom);
        aritmetico = 1'($urandom);
        n = 0;
        while (!done && n < 20) begin
            check("busy_during", {31'd0, busy}, 1);
            @(negedge clk);
            n++;
        end
        check("latency", n, k + 1);
        check("busy_in_done", {31'd0, busy}, 1);
        check("result", {24'd0, desplazados}, {24'd0, exp});
        last_res = desplazados;
        @(negedge clk);
        start = 1'b0;
        check("done_one_pulse", {31'd0, done}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("result_hold", {24'd0, desplazados}, {24'd0, exp});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_res", {24'd0, desplazados}, 0);
        rst = 1'b0;

        run_shift(8'hB4, 3, 1'b0, 1'b0); check("s1_const", {24'd0, last_res}, 32'h16);
        run_shift(8'hB4, 3, 1'b1, 1'b0); check("s2_const", {24'd0, last_res}, 32'hF6);
        run_shift(8'hB4, 0, 1'b0, 1'b0); check("s3_const", {24'd0, last_res}, 32'hB4);
        run_shift(8'h80, 7, 1'b1, 1'b0); check("s4a_const", {24'd0, last_res}, 32'hFF);
        run_shift(8'h80, 7, 1'b0, 1'b0); check("s4l_const", {24'd0, last_res}, 32'h01);
        run_shift(8'hB4, 3, 1'b0, 1'b1); check("s5_const", {24'd0, last_res}, 32'h16);
        run_shift(8'h0F, 1, 1'b0, 1'b0); check("s5_next", {24'd0, last_res}, 32'h07);

        for (int i = 0; i < 40; i++)
            run_shift(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));

        @(negedge clk);
        start = 1'b1;
        desplazar = 8'hB4;
        cantidad = 3'd7;
        aritmetico = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_done", {31'd0, done}, 0);
        check("async_rst_res", {24'd0, desplazados}, 0);
        #1 rst = 1'b0;
        run_shift(8'hC3, 2, 1'b1, 1'b0); check("post_rst_const", {24'd0, last_res}, 32'hF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
